restoring_divider: RTL and testbench

- Multi-cycle unsigned integer divider for the arithmetic datapath.
- Consumes WIDTH-bit dividend/divisor pairs and produces quotient and remainder by the restoring method, one trial subtraction per clock.
- Sits directly downstream of the operand-select stage and beside the adder/subtractor blocks.
- Uses valid/ready handshakes on both sides so the ALU sequencer can stall it.

---
 rtl/restoring_divider_pkg.sv | 15 +
 rtl/restoring_div_step.sv | 38 +++
 rtl/restoring_divider.sv | 158 +++++++++++++++
 tb/tb_restoring_divider.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/restoring_divider_pkg.sv
// Shared constants for the restoring divider.
//   div_state_e       : FSM state encoding (IDLE / RUN / DONE; 2'b11 is unused)
//   DIV_ZERO_QUOTIENT : quotient reported for a zero divisor (all ones); the top
//                       slices it down to its own WIDTH.
package restoring_divider_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_RUN  = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

    localparam logic [31:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;

endpackage

// File: rtl/restoring_div_step.sv
// One restoring-division iteration, purely combinational.
//   r_in   [WIDTH:0]   : current partial remainder
//   q_msb              : next dividend bit shifted into the remainder
//   d_in   [WIDTH-1:0] : divisor
//   r_out  [WIDTH:0]   : partial remainder after the trial subtraction/restore
//   q_bit              : quotient bit produced by this iteration
module restoring_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   r_in,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH:0]   r_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] trial_s;
    // The remainder's top bit is always zero between iterations (R < D), so
    // the shift drops it; kept only so R stays WIDTH+1 bits end to end.
    logic           unused_r_msb_s;

    assign unused_r_msb_s = r_in[WIDTH];

    // Shift in the next dividend bit, try subtracting D, restore on borrow.
    always_comb begin
        shifted_s = {r_in[WIDTH-1:0], q_msb};
        trial_s   = shifted_s - {1'b0, d_in};
        if (trial_s[WIDTH] == 1'b0) begin
            r_out = trial_s;
            q_bit = 1'b1;
        end else begin
            r_out = shifted_s;
            q_bit = 1'b0;
        end
    end

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned divider using the restoring method, one trial
// subtraction per clock, with valid/ready handshakes on both sides.
//   clk         : clock, rising edge
//   rst         : asynchronous active-low reset
//   in_valid    : operands presented      in_ready  : accepting (IDLE only)
//   dividend    : numerator (sampled at acceptance)
//   divisor     : denominator (sampled at acceptance)
//   out_valid   : result valid (DONE only) out_ready : consumer takes result
//   quotient    : unsigned quotient        remainder : unsigned remainder
//   div_by_zero : divisor of this result was zero
//   busy        : iterating (RUN)
module restoring_divider
    import restoring_divider_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    div_state_e       state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [WIDTH:0]   r_q,         r_d;
    logic [WIDTH-1:0] q_q,         q_d;
    logic [WIDTH-1:0] d_q,         d_d;
    logic [WIDTH-1:0] quotient_q,  quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q,       dbz_d;
    logic             in_ready_q,  in_ready_d;
    logic             busy_q,      busy_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH:0]   step_r_s;
    logic             step_q_bit_s;
    logic [WIDTH-1:0] q_shift_s;

    restoring_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r_in  (r_q),
        .q_msb (q_q[WIDTH-1]),
        .d_in  (d_q),
        .r_out (step_r_s),
        .q_bit (step_q_bit_s)
    );

    // Next-state, datapath and handshake flag computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        r_d         = r_q;
        q_d         = q_q;
        d_d         = d_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        q_shift_s   = {q_q[WIDTH-2:0], step_q_bit_s};

        case (state_q)
            DIV_IDLE: begin
                if (in_valid && in_ready_q) begin
                    if (divisor != {WIDTH{1'b0}}) begin
                        d_d     = divisor;
                        q_d     = dividend;
                        r_d     = {(WIDTH+1){1'b0}};
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = DIV_RUN;
                    end else begin
                        // Zero divisor: answer immediately, no iterations.
                        quotient_d  = DIV_ZERO_QUOTIENT[WIDTH-1:0];
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = DIV_DONE;
                    end
                end else begin
                    state_d = DIV_IDLE;
                end
            end
            DIV_RUN: begin
                r_d   = step_r_s;
                q_d   = q_shift_s;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // Last iteration: publish the freshly computed values.
                    quotient_d  = q_shift_s;
                    remainder_d = step_r_s[WIDTH-1:0];
                    dbz_d       = 1'b0;
                    state_d     = DIV_DONE;
                end else begin
                    state_d = DIV_RUN;
                end
            end
            DIV_DONE: begin
                if (out_ready) begin
                    state_d = DIV_IDLE;
                end else begin
                    state_d = DIV_DONE;
                end
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase

        // Handshake flags are registered copies of the next state.
        in_ready_d  = (state_d == DIV_IDLE);
        busy_d      = (state_d == DIV_RUN);
        out_valid_d = (state_d == DIV_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= DIV_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            r_q         <= {(WIDTH+1){1'b0}};
            q_q         <= {WIDTH{1'b0}};
            d_q         <= {WIDTH{1'b0}};
            quotient_q  <= {WIDTH{1'b0}};
            remainder_q <= {WIDTH{1'b0}};
            dbz_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            q_q         <= q_d;
            d_q         <= d_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign busy        = busy_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed bench for restoring_divider with a result scoreboard.
module tb_restoring_divider;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             busy;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dbz;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    restoring_divider #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Exactly one of in_ready / busy / out_valid must be high at all times.
    always @(negedge clk) begin
        chk("state_onehot", {63'd0, $onehot({in_ready, busy, out_valid})}, 64'd1);
    end

    // Drive one operation, wait for its result, compare against the
    // scoreboard, optionally stall the consumer, then hand the result off.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input int stall, input bit inject);
        exp_t e;
        exp_t got;
        int   lat;
        e.q   = (b == 0) ? {WIDTH{1'b1}} : a / b;
        e.r   = (b == 0) ? a : a % b;
        e.dbz = (b == 0);

        @(negedge clk);
        chk({tag, "_in_ready"}, in_ready, 1);
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        sb.push_back(e);
        @(posedge clk);
        #1;
        // Operands must only matter at acceptance.
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        if (b == 0) begin
            chk({tag, "_busy_dbz"}, busy, 0);
        end else begin
            chk({tag, "_busy_run"}, busy, 1);
        end

        // Edges after the acceptance edge until out_valid shows.
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (inject && lat == 5) begin
                dividend = 32'd12345;
                divisor  = 32'd0;
                in_valid = 1'b1;
            end
            if (inject && lat == 6) begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
            if (b == 0) begin
                chk({tag, "_busy_dbz_wait"}, busy, 0);
            end
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, lat, (b == 0) ? 0 : WIDTH);

        chk({tag, "_sb_nonempty"}, (sb.size() > 0), 1);
        if (sb.size() > 0) begin
            got = sb.pop_front();
            chk({tag, "_quotient"}, quotient, got.q);
            chk({tag, "_remainder"}, remainder, got.r);
            chk({tag, "_dbz"}, div_by_zero, got.dbz);
        end

        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_stall_valid"}, out_valid, 1);
            chk({tag, "_stall_q"}, quotient, e.q);
            chk({tag, "_stall_r"}, remainder, e.r);
            chk({tag, "_stall_in_ready"}, in_ready, 0);
        end
        if (stall > 0) begin
            @(negedge clk);
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk({tag, "_handoff_valid"}, out_valid, 0);
        chk({tag, "_handoff_in_ready"}, in_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit saw_valid;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        #1;
        rst = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_op("basic", 32'd100, 32'd7, 0, 1'b0);
        run_op("div0", 32'h0000_1234, 32'd0, 0, 1'b0);
        run_op("max_by_1", 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
        run_op("max_by_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("small", 32'd5, 32'd9, 0, 1'b0);
        run_op("backpressure", 32'd1000, 32'd33, 10, 1'b0);
        run_op("ignored_in", 32'd100, 32'd7, 0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            run_op("rand", $urandom, $urandom_range(1, 1000), 0, 1'b0);
        end

        // Reset during iteration 10 of 100/7: the result must vanish.
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        saw_valid = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) saw_valid = 1'b1;
        end
        chk("midrst_no_pulse", saw_valid, 0);
        run_op("after_rst", 32'd9, 32'd3, 0, 1'b0);

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
